mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access unit for the MEM stage of the pipelined datapath. It consumes the 2-bit MemRead/MemWrite size codes issued by the main decoder (01 = word, 10 = byte, 11 = halfword, 00 = none) and turns them into a word-wide, byte-enabled request/acknowledge bus transaction. It returns sign-extended load data and stalls the pipeline while the access is outstanding. Misaligned accesses and unacknowledged bus cycles are reported as errors and never hang the pipeline.

## Interface
Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT, 15, maximum cycles spent in BUS without mem_ack before bus error; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset.
- MemRead  in  2  load size code from EX/MEM register.
- MemWrite  in  2  store size code from EX/MEM register.
- addr  in  ADDR_W  byte address (ALU result).
- wdata  in  32  store data (rt).
- stall  out  1  freeze IF/ID/EX/MEM registers.
- rdata  out  32  load result, sign-extended.
- rvalid  out  1  one-cycle pulse, load data valid.
- align_err  out  1  one-cycle pulse, misaligned access rejected.
- bus_err  out  1  one-cycle pulse, bus timeout.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word-aligned address, with addr[1:0] forced to 00.
- mem_be  out  4  byte enables; bit k selects bits 8k+7:8k.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word, valid with mem_ack.
- mem_ack  in  1  completes the current request.

## Operation
- FSM states: IDLE, BUS, DONE. Reset state is IDLE.
- Request present means MemRead != 00 or MemWrite != 00. When both are nonzero, MemWrite wins and the read is ignored.
- Lane mapping is little-endian:
  - byte: mem_be = 0001 << addr[1:0].
  - half: addr[1]=0 gives 0011; addr[1]=1 gives 1100.
  - word: 1111.
- Alignment rules: a halfword requires addr[0]=0; a word requires addr[1:0]=00.
- Store data replication: a byte store puts wdata[7:0] on all four lanes; a half store puts wdata[15:0] on both halves; a word store passes wdata through.
- Load extraction: select the addressed lane(s) from mem_rdata, then sign-extend to 32 bits.
- IDLE with a request:
  - Aligned: latch mem_addr, mem_be, mem_we, mem_wdata and the size; go to BUS.
  - Misaligned: go to DONE with an error flag; no bus cycle is issued.
- BUS: mem_req=1 and all mem_* outputs are held stable.
  - mem_ack=1: capture mem_rdata; go to DONE.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT, drop mem_req and go to DONE with bus_err pending.
- DONE: lasts exactly one cycle, then returns to IDLE.
  - rvalid=1 only for a successful load.
  - align_err or bus_err pulses if flagged; rdata=0 on any error.
- stall (combinational):
  - 1 in IDLE when a request is present.
  - 1 in BUS.
  - 0 in DONE, so the pipeline advances at the end of DONE and the same request is never re-accepted.
- mem_ack is ignored outside BUS.
- Reset values: stall=0, rdata=0, rvalid=0, align_err=0, bus_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0000, mem_wdata=0, timeout counter=0.

## Timing
- Presentation cycle is C0; stall is high in C0.
- Zero-wait access: mem_req=1 in C1; mem_ack in C1; DONE in C2 with rvalid/rdata valid and stall=0. Minimum throughput is 1 access per 3 cycles.
- Each wait cycle without ack extends BUS by one cycle.
- Timeout: mem_req stays high for exactly TIMEOUT cycles; bus_err pulses in the following cycle.
- Misaligned access: stall in C0 only; align_err pulses in C1; mem_req never rises.
- mem_req deasserts in the cycle after mem_ack is sampled.
- Reset mid-operation: asynchronous. mem_req and stall drop immediately, the FSM returns to IDLE, and the pending transaction is abandoned with no error pulse.
- No request in IDLE: all pulse outputs stay 0 and mem_* outputs hold their last values with mem_req=0.

## Test plan
- Word load: MemRead=01, addr=0x100, mem_rdata=0x8000_00FF, ack in C1 -> mem_be=1111, mem_addr=0x100; rdata=0x8000_00FF with rvalid in C2; stall high for C0–C1.
- Byte/half sign extension: lb at addr=0x103 with mem_rdata=0x80_12_34_56 -> mem_be=1000, rdata=0xFFFF_FF80. lh at addr=0x102 -> mem_be=1100, rdata=0xFFFF_8012.
- Stores: sb at addr=0x201 with wdata=0xAB -> mem_we=1, mem_be=0010, mem_wdata=0xABAB_ABAB. sh at addr=0x202 with wdata=0x1234 -> mem_be=1100, mem_wdata=0x1234_1234.
- Misaligned: lw at addr=0x102 -> no mem_req, align_err pulse in C1, rvalid=0. Also sh at addr=0x3 -> same behaviour.
- Wait states and timeout: ack after 3 waits -> stall for 5 cycles total, correct data. No ack with TIMEOUT=15 -> mem_req high for 15 cycles, then bus_err pulse, rdata=0.
- Priority and reset: MemRead=01 with MemWrite=01 simultaneously -> write performed. Reset asserted in BUS -> mem_req=0 and stall=0 immediately; the next request proceeds normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit driving a byte-enabled req/ack data bus
//   in : clk, reset (async, active-high), MemRead/MemWrite size codes (01 word, 10 byte, 11 half),
//        addr, wdata, mem_rdata, mem_ack
//   out: stall (combinational), rdata (sign-extended), rvalid/align_err/bus_err pulses,
//        mem_req, mem_we, mem_addr (word aligned), mem_be, mem_wdata (lane replicated)
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        MemRead,
  input  logic [1:0]        MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              align_err,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        w_wr;
  logic [1:0]  w_size;
  logic        w_req;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_lane;
  logic [15:0] w_half;
  logic [31:0] w_load;
  always_comb begin
    w_wr    = MemWrite != 2'b00;
    w_size  = w_wr ? MemWrite : MemRead;
    w_req   = w_size != 2'b00;
    w_mis   = (w_size == 2'b01 && addr[1:0] != 2'b00) || (w_size == 2'b11 && addr[0]);
    w_be    = w_size == 2'b01 ? 4'b1111 : w_size == 2'b10 ? 4'b0001 << addr[1:0] : addr[1] ? 4'b1100 : 4'b0011;
    w_wdata = w_size == 2'b10 ? {4{wdata[7:0]}} : w_size == 2'b11 ? {2{wdata[15:0]}} : wdata;
    w_lane  = 8'(mem_rdata >> {r_off, 3'b000});
    w_half  = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_load  = r_size == 2'b01 ? mem_rdata : r_size == 2'b10 ? {{24{w_lane[7]}}, w_lane} : {{16{w_half[15]}}, w_half};
  end
  // Low in DONE so the pipeline advances past the request instead of re-issuing it
  assign stall = !reset && (r_state == BUS || (r_state == IDLE && w_req));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_size    <= 2'b00;
      r_off     <= 2'b00;
      rdata     <= 32'd0;
      rvalid    <= 1'b0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'd0;
    end else begin
      rvalid    <= 1'b0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      case (r_state)
        IDLE: if (w_req) begin
          if (w_mis) begin
            r_state   <= DONE;
            align_err <= 1'b1;
            rdata     <= 32'd0;
          end else begin
            r_state   <= BUS;
            r_cnt     <= 8'd0;
            r_size    <= w_size;
            r_off     <= addr[1:0];
            mem_req   <= 1'b1;
            mem_we    <= w_wr;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_be    <= w_be;
            mem_wdata <= w_wdata;
          end
        end
        BUS: if (mem_ack) begin
          r_state <= DONE;
          r_cnt   <= 8'd0;
          mem_req <= 1'b0;
          rdata   <= mem_we ? 32'd0 : w_load;
          rvalid  <= !mem_we;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          r_state <= DONE;
          r_cnt   <= 8'd0;
          mem_req <= 1'b0;
          bus_err <= 1'b1;
          rdata   <= 32'd0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table, hand-sequence and random checks of mem_access_unit against a byte-level model
module tb_mem_access_unit;
  localparam int TO = 15;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  MemRead = 2'b00, MemWrite = 2'b00;
  logic [31:0] addr = 32'd0, wdata = 32'd0, mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        stall, rvalid, align_err, bus_err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int          checks = 0, errors = 0, cyc = 0;
  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rvalid(rvalid), .align_err(align_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [1:0] mr, mw;
    logic [31:0] a, wd, rd;
    int waits, stl, req;
    logic [3:0] be;
    logic we;
    logic [31:0] maddr, mwd, rdata;
    logic rv, ae, bev;
  } vec_t;
  typedef struct {
    int stl, req, prv, pae, pbe, done_cyc;
    logic [3:0] be;
    logic we;
    logic [31:0] maddr, mwd, rdata;
    logic rv, ae, bev, stable, hung;
  } obs_t;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic vec_t model(input logic [1:0] mr, mw, input logic [31:0] a, wd, rd, input int waits);
    vec_t e;
    int n, off;
    bit acked;
    longint unsigned v;
    e = '{mr, mw, a, wd, rd, waits, 0, 0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    e.we = mw != 0;
    n = (e.we ? mw : mr) == 2'd1 ? 4 : (e.we ? mw : mr) == 2'd2 ? 1 : 2;
    off = int'(a % 4);
    if (mr == 0 && mw == 0) return e;
    if (a % n != 0) begin
      e.stl = 1;
      e.ae = 1'b1;
      return e;
    end
    acked = waits < TO;
    e.req = acked ? waits + 1 : TO;
    e.stl = e.req + 1;
    e.be = 4'(((1 << n) - 1) << off);
    e.maddr = a - 32'(off);
    for (int k = 0; k < 4; k++) e.mwd[8*k +: 8] = wd[8*(k % n) +: 8];
    e.rv = acked && !e.we;
    e.bev = !acked;
    if (e.rv) begin
      v = (longint'(rd) >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
      if (v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
      e.rdata = v[31:0];
    end
    return e;
  endfunction
  task automatic run_txn(input vec_t t, input bit noise, input bit idle, output obs_t o);
    bit done = 0;
    int n = 0;
    o = '{0, 0, 0, 0, 0, 0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    MemRead = t.mr; MemWrite = t.mw; addr = t.a; wdata = t.wd; mem_rdata = $urandom;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
      o.prv += int'(rvalid); o.pae += int'(align_err); o.pbe += int'(bus_err);
      if (!stall) begin
        done = 1;
        if (mem_req) o.req++;
        o.rdata = rdata; o.rv = rvalid; o.ae = align_err; o.bev = bus_err; o.done_cyc = cyc;
      end else begin
        o.stl++;
        if (mem_req) begin
          if (o.req == 0) begin
            o.be = mem_be; o.we = mem_we; o.maddr = mem_addr; o.mwd = mem_wdata;
          end else if ({mem_be, mem_we, mem_addr, mem_wdata} != {o.be, o.we, o.maddr, o.mwd}) o.stable = 1'b0;
          mem_ack = o.req == t.waits;
          mem_rdata = mem_ack ? t.rd : $urandom;
          o.req++;
        end else mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
    end
    o.hung = !done;
    @(posedge clk); #1;
    MemRead = 2'b00; MemWrite = 2'b00;
    if (idle) begin
      @(negedge clk);
      o.prv += int'(rvalid); o.pae += int'(align_err); o.pbe += int'(bus_err);
      if (mem_req) o.req++;
      @(posedge clk); #1;
    end
  endtask
  task automatic check_obs(input string tag, input vec_t e, input obs_t o);
    chk({tag, " hung"}, longint'(o.hung), 0);
    chk({tag, " stall_cycles"}, o.stl, e.stl);
    chk({tag, " req_cycles"}, o.req, e.req);
    if (e.req > 0) begin
      chk({tag, " mem_be"}, o.be, e.be);
      chk({tag, " mem_we"}, o.we, e.we);
      chk({tag, " mem_addr"}, o.maddr, e.maddr);
      chk({tag, " bus_stable"}, o.stable, 1);
      if (e.we) chk({tag, " mem_wdata"}, o.mwd, e.mwd);
    end
    chk({tag, " rvalid"}, o.rv, e.rv);
    chk({tag, " align_err"}, o.ae, e.ae);
    chk({tag, " bus_err"}, o.bev, e.bev);
    chk({tag, " pulses"}, {o.prv, o.pae, o.pbe}, {32'(e.rv), 32'(e.ae), 32'(e.bev)});
    if (e.rv || e.ae || e.bev) chk({tag, " rdata"}, o.rdata, e.rdata);
  endtask
  vec_t tbl[12];
  initial begin
    obs_t o, o2;
    vec_t e;
    tbl[0]  = '{2'b01, 2'b00, 32'h100, 32'h0, 32'h800000FF, 0, 2, 1, 4'hF, 1'b0, 32'h100, 32'h0, 32'h800000FF, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{2'b10, 2'b00, 32'h103, 32'h0, 32'h80123456, 0, 2, 1, 4'h8, 1'b0, 32'h100, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{2'b11, 2'b00, 32'h102, 32'h0, 32'h80123456, 0, 2, 1, 4'hC, 1'b0, 32'h100, 32'h0, 32'hFFFF8012, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{2'b00, 2'b10, 32'h201, 32'hAB, 32'h0, 0, 2, 1, 4'h2, 1'b1, 32'h200, 32'hABABABAB, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{2'b00, 2'b11, 32'h202, 32'h1234, 32'h0, 0, 2, 1, 4'hC, 1'b1, 32'h200, 32'h12341234, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{2'b01, 2'b00, 32'h102, 32'h0, 32'h0, 0, 1, 0, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{2'b00, 2'b11, 32'h3, 32'h5555, 32'h0, 0, 1, 0, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{2'b01, 2'b00, 32'h104, 32'h0, 32'h12345678, 3, 5, 4, 4'hF, 1'b0, 32'h104, 32'h0, 32'h12345678, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{2'b01, 2'b01, 32'h300, 32'hDEADBEEF, 32'h0, 0, 2, 1, 4'hF, 1'b1, 32'h300, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{2'b10, 2'b00, 32'h101, 32'h0, 32'h80123456, 0, 2, 1, 4'h2, 1'b0, 32'h100, 32'h0, 32'h00000034, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{2'b11, 2'b00, 32'h100, 32'h0, 32'h1234F00F, 0, 2, 1, 4'h3, 1'b0, 32'h100, 32'h0, 32'hFFFFF00F, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{2'b01, 2'b00, 32'h40, 32'h0, 32'hCAFEF00D, 99, 16, 15, 4'hF, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    chk("reset outputs", {stall, rdata, rvalid, align_err, bus_err, mem_req, mem_we}, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_be", mem_be, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i], 1'b0, 1'b1, o);
      check_obs($sformatf("tbl%0d", i), tbl[i], o);
    end
    run_txn(tbl[0], 1'b0, 1'b0, o);
    run_txn(tbl[1], 1'b0, 1'b1, o2);
    check_obs("b2b_second", tbl[1], o2);
    chk("b2b spacing", o2.done_cyc - o.done_cyc, 3);
    MemRead = 2'b01; addr = 32'h500;
    @(negedge clk);
    chk("rst_mid C0 stall", stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid C1 mem_req", mem_req, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid req/stall", {mem_req, stall}, 0);
    @(posedge clk); #1;
    MemRead = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid no pulses", {rvalid, align_err, bus_err, mem_req}, 0);
    @(posedge clk); #1;
    run_txn(tbl[0], 1'b0, 1'b1, o);
    check_obs("post_reset", tbl[0], o);
    for (int i = 0; i < 200; i++) begin
      int sel, w;
      logic [1:0] mr, mw;
      sel = $urandom_range(0, 9);
      mr = 2'($urandom_range(1, 3));
      mw = 2'($urandom_range(1, 3));
      if (sel == 0) begin mr = 0; mw = 0; end
      else if (sel < 5) mw = 0;
      else if (sel < 9) mr = 0;
      w = $urandom_range(0, 15) == 0 ? $urandom_range(TO - 1, TO + 4) : $urandom_range(0, 4);
      e = model(mr, mw, $urandom, $urandom, $urandom, w);
      run_txn(e, 1'b1, 1'($urandom_range(0, 1)), o);
      check_obs($sformatf("rnd%0d", i), e, o);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
